decode_front: RTL and testbench
===============================

// Module: decode_front
// PURPOSE
//  Decode-side partner of the fetch stage. Holds the IF/ID pipeline register and resolves beq/bne/j in decode.
//  Drives pc_branch_d/pcsrc_d back into fetch. Detects load-use and branch-operand hazards and drives stallf.
//  Sits between fetch and the ID/EX register. The register file is external: rs_d/rt_d go out, rd1_d/rd2_d come back.
// PARAMETERS
//  WIDTH       32        datapath/address width
//  RA_W        5         register-number width
//  NOP_INSTR   32'h0     bubble loaded on flush (sll $0,$0,0)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      synchronous, active-high
//  pc_plus_4f   in   WIDTH  from fetch
//  instructionf in   WIDTH  from fetch
//  rd1_d        in   WIDTH  regfile read data for rs_d
//  rd2_d        in   WIDTH  regfile read data for rt_d
//  aluout_m     in   WIDTH  MEM-stage ALU result (forwarding)
//  writereg_e   in   RA_W   EX destination reg;  regwrite_e, memtoreg_e in 1 each
//  writereg_m   in   RA_W   MEM destination reg; regwrite_m, memtoreg_m in 1 each
//  pc_branch_d  out  WIDTH  branch/jump target to fetch
//  pcsrc_d      out  1      1 = fetch takes pc_branch_d
//  stallf       out  1      freeze PC
//  flush_e      out  1      insert bubble into ID/EX
//  instr_d      out  WIDTH  registered instruction
//  pc_plus_4d   out  WIDTH  registered PC+4
//  rs_d, rt_d, rd_d out RA_W  instr_d[25:21], [20:16], [15:11]
//  signimm_d    out  WIDTH  sign-extended instr_d[15:0]
// BEHAVIOUR
//  Reset: instr_d=NOP_INSTR, pc_plus_4d=0. Hence pcsrc_d=0, stallf=0, flush_e=0, pc_branch_d=0 one cycle after reset.
//  Reset mid-stall or mid-branch discards the held instruction; the next cycle restarts from the NOP state.
//  IF/ID update each rising edge, priority: reset > stall (hold) > flush (load NOP_INSTR, pc_plus_4d=0) > load f-inputs.
//  Hazards (combinational on registered state; $0 never hazards):
//   lwstall = memtoreg_e & (writereg_e==rs_d | writereg_e==rt_d)
//   brstall = (beq|bne) & ((regwrite_e & writereg_e∈{rs_d,rt_d}) | (memtoreg_m & writereg_m∈{rs_d,rt_d}))
//   stall = lwstall|brstall; stallf = stall; flush_e = stall.
//  Forwarding into the compare: srca = (rs_d!=0 & regwrite_m & writereg_m==rs_d) ? aluout_m : rd1_d; srcb likewise for rt_d.
//  Resolution: eq = (srca==srcb); take = (beq&eq)|(bne&~eq)|j; pcsrc_d = take & ~stall (stale operands never redirect).
//  Target: beq/bne -> pc_plus_4d + (signimm_d<<2), modulo 2^WIDTH (wrap ignored). j -> {pc_plus_4d[31:28],instr_d[25:0],2'b00}.
//  Flush of IF/ID = pcsrc_d. This squashes the delay-slot fetch; no architectural delay slot exists.
//  Branch latency: redirect visible to fetch the same cycle the branch sits in D. Penalty is 1 bubble if taken, +1 per stall cycle.
//  Stall and branch in the same cycle: the stall wins. The branch is re-evaluated next cycle with forwarded data.
//  Multi-cycle stall: instr_d/pc_plus_4d hold; flush_e is asserted every stalled cycle.
// STRUCTURE
//  Shared in util.v as `defines: OP_BEQ 6'h04, OP_BNE 6'h05, OP_J 6'h02, OP_LW 6'h23, NOP encoding.
//  One sub-module, hazard_unit: pure combinational lwstall/brstall/forward-select. Top holds the IF/ID register and target logic.
//  Reuses existing adder for the target add.
// TESTING
//  1 reset held 3 cycles with instructionf=32'h1234_5678 -> instr_d=0, pcsrc_d=0, stallf=0; first edge after reset loads 32'h1234_5678.
//  2 beq $1,$2,+3 at pc_plus_4=0x104, rd1=rd2=7, no hazards -> pcsrc_d=1, pc_branch_d=0x110; next cycle instr_d=NOP.
//  3 bne $1,$2,-1 at pc_plus_4=0x0, rd1=rd2 -> pcsrc_d=0. With rd1!=rd2 -> pc_branch_d=0xFFFF_FFFC (wrap).
//  4 lw $3 in EX, instr_d=add $4,$3,$5 -> stallf=1, flush_e=1 for 1 cycle; instr_d held; then stallf=0.
//  5 beq $3,$0 with regwrite_e & writereg_e=3 -> stall 1 cycle, pcsrc_d=0 while stalled. Next cycle aluout_m=0 forwarded -> pcsrc_d=1.
//  6 j 0x0000040 with pc_plus_4d=0xA000_0008 -> pc_branch_d=0xA000_0100, pcsrc_d=1.
//    Assert reset that same cycle -> next cycle pcsrc_d=0, instr_d=0.

Source files
------------

// File: rtl/decode_front_pkg.sv
// Shared decode definitions for the decode front end.
// Contents: opcode encodings for the instructions resolved in decode,
// the bubble encoding, and an opcode classification helper.
package decode_front_pkg;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05,
      OP_LW    = 6'h23
   } opcode_e;

   // sll $0,$0,0
   localparam logic [31:0] NOP_ENC = 32'h0000_0000;

   function automatic logic is_cond_branch(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/decode_front_hazard_unit.sv
// Combinational hazard detection and compare-operand forward select.
// Ports:
//   rs_d, rt_d          source registers of the instruction in decode
//   is_branch           decode holds beq/bne
//   writereg_e/m        destination register in EX / MEM
//   regwrite_e/m        EX / MEM instruction writes the register file
//   memtoreg_e/m        EX / MEM instruction is a load
//   stall               freeze fetch and decode, bubble into ID/EX
//   fwd_a, fwd_b        take aluout_m instead of regfile data for rs/rt
module hazard_unit #(
   parameter int unsigned RA_W = 5
) (
   input  logic [RA_W-1:0] rs_d,
   input  logic [RA_W-1:0] rt_d,
   input  logic            is_branch,
   input  logic [RA_W-1:0] writereg_e,
   input  logic            regwrite_e,
   input  logic            memtoreg_e,
   input  logic [RA_W-1:0] writereg_m,
   input  logic            regwrite_m,
   input  logic            memtoreg_m,
   output logic            stall,
   output logic            fwd_a,
   output logic            fwd_b
);

   logic hit_e;
   logic hit_m;
   logic lwstall;
   logic brstall;

   // $0 is hardwired to zero, so a write to it never creates a dependency.
   always_comb begin
      hit_e   = (writereg_e != '0) && ((writereg_e == rs_d) || (writereg_e == rt_d));
      hit_m   = (writereg_m != '0) && ((writereg_m == rs_d) || (writereg_m == rt_d));
      lwstall = memtoreg_e && hit_e;
      // A load in MEM cannot forward its data yet; an ALU result in EX is not
      // available at all. Either way the compare would see stale operands.
      brstall = is_branch && ((regwrite_e && hit_e) || (memtoreg_m && hit_m));
      stall   = lwstall || brstall;
      fwd_a   = (rs_d != '0) && regwrite_m && (writereg_m == rs_d);
      fwd_b   = (rt_d != '0) && regwrite_m && (writereg_m == rt_d);
   end

endmodule

// File: rtl/decode_front.sv
// Decode front end: IF/ID pipeline register, early beq/bne/j resolution and
// hazard-driven stall/flush.
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   pc_plus_4f, instructionf    fetch outputs captured into IF/ID
//   rd1_d, rd2_d                regfile read data for rs_d / rt_d
//   aluout_m                    MEM-stage ALU result for compare forwarding
//   writereg_e/m, regwrite_e/m, memtoreg_e/m   downstream hazard info
//   pc_branch_d, pcsrc_d        redirect target and select back to fetch
//   stallf, flush_e             freeze PC / bubble into ID/EX
//   instr_d, pc_plus_4d         registered instruction and PC+4
//   rs_d, rt_d, rd_d, signimm_d decoded register fields and immediate
module decode_front
   import decode_front_pkg::*;
#(
   parameter int unsigned     WIDTH     = 32,
   parameter int unsigned     RA_W      = 5,
   parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(NOP_ENC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pc_plus_4f,
   input  logic [WIDTH-1:0] instructionf,
   input  logic [WIDTH-1:0] rd1_d,
   input  logic [WIDTH-1:0] rd2_d,
   input  logic [WIDTH-1:0] aluout_m,
   input  logic [RA_W-1:0]  writereg_e,
   input  logic             regwrite_e,
   input  logic             memtoreg_e,
   input  logic [RA_W-1:0]  writereg_m,
   input  logic             regwrite_m,
   input  logic             memtoreg_m,
   output logic [WIDTH-1:0] pc_branch_d,
   output logic             pcsrc_d,
   output logic             stallf,
   output logic             flush_e,
   output logic [WIDTH-1:0] instr_d,
   output logic [WIDTH-1:0] pc_plus_4d,
   output logic [RA_W-1:0]  rs_d,
   output logic [RA_W-1:0]  rt_d,
   output logic [RA_W-1:0]  rd_d,
   output logic [WIDTH-1:0] signimm_d
);

   logic [5:0]       op;
   logic             is_beq;
   logic             is_bne;
   logic             is_j;
   logic             stall;
   logic             fwd_a;
   logic             fwd_b;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             eq;
   logic             take;
   logic [WIDTH-1:0] br_target;
   logic [WIDTH-1:0] j_target;

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_d    <= NOP_INSTR;
         pc_plus_4d <= '0;
      end else if (stall) begin
         instr_d    <= instr_d;
         pc_plus_4d <= pc_plus_4d;
      end else if (pcsrc_d) begin
         // squash the fetch behind a taken branch/jump
         instr_d    <= NOP_INSTR;
         pc_plus_4d <= '0;
      end else begin
         instr_d    <= instructionf;
         pc_plus_4d <= pc_plus_4f;
      end
   end

   always_comb begin
      op        = instr_d[31:26];
      is_beq    = (op == OP_BEQ);
      is_bne    = (op == OP_BNE);
      is_j      = (op == OP_J);
      rs_d      = instr_d[21 +: RA_W];
      rt_d      = instr_d[16 +: RA_W];
      rd_d      = instr_d[11 +: RA_W];
      signimm_d = {{(WIDTH-16){instr_d[15]}}, instr_d[15:0]};
   end

   hazard_unit #(
      .RA_W (RA_W)
   ) u_hazard (
      .rs_d       (rs_d),
      .rt_d       (rt_d),
      .is_branch  (is_cond_branch(op)),
      .writereg_e (writereg_e),
      .regwrite_e (regwrite_e),
      .memtoreg_e (memtoreg_e),
      .writereg_m (writereg_m),
      .regwrite_m (regwrite_m),
      .memtoreg_m (memtoreg_m),
      .stall      (stall),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b)
   );

   always_comb begin
      srca      = fwd_a ? aluout_m : rd1_d;
      srcb      = fwd_b ? aluout_m : rd2_d;
      eq        = (srca == srcb);
      take      = (is_beq && eq) || (is_bne && !eq) || is_j;
      // a stalled branch is looking at stale operands and must not redirect
      pcsrc_d   = take && !stall;
      stallf    = stall;
      flush_e   = stall;
      br_target = pc_plus_4d + {signimm_d[WIDTH-3:0], 2'b00};
      j_target  = {pc_plus_4d[WIDTH-1:28], instr_d[25:0], 2'b00};
      pc_branch_d = is_j ? j_target : br_target;
   end

endmodule

// File: tb/tb_decode_front.sv
module tb_decode_front;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_plus_4f, instructionf, rd1_d, rd2_d, aluout_m;
   logic [4:0]  writereg_e, writereg_m;
   logic        regwrite_e, memtoreg_e, regwrite_m, memtoreg_m;
   logic [31:0] pc_branch_d, instr_d, pc_plus_4d, signimm_d;
   logic        pcsrc_d, stallf, flush_e;
   logic [4:0]  rs_d, rt_d, rd_d;

   int pass_cnt = 0;
   int total_cnt = 0;

   decode_front #(
      .WIDTH     (32),
      .RA_W      (5),
      .NOP_INSTR (32'h0)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_plus_4f   (pc_plus_4f),
      .instructionf (instructionf),
      .rd1_d        (rd1_d),
      .rd2_d        (rd2_d),
      .aluout_m     (aluout_m),
      .writereg_e   (writereg_e),
      .regwrite_e   (regwrite_e),
      .memtoreg_e   (memtoreg_e),
      .writereg_m   (writereg_m),
      .regwrite_m   (regwrite_m),
      .memtoreg_m   (memtoreg_m),
      .pc_branch_d  (pc_branch_d),
      .pcsrc_d      (pcsrc_d),
      .stallf       (stallf),
      .flush_e      (flush_e),
      .instr_d      (instr_d),
      .pc_plus_4d   (pc_plus_4d),
      .rs_d         (rs_d),
      .rt_d         (rt_d),
      .rd_d         (rd_d),
      .signimm_d    (signimm_d)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_hazards();
      writereg_e = 5'd0; regwrite_e = 1'b0; memtoreg_e = 1'b0;
      writereg_m = 5'd0; regwrite_m = 1'b0; memtoreg_m = 1'b0;
      aluout_m   = 32'h0;
   endtask

   // Bring IF/ID to a known instruction: first a NOP edge (load or flush both
   // give NOP), then the requested instruction.
   task automatic load(input logic [31:0] ins, input logic [31:0] pc4);
      clear_hazards();
      rd1_d = 32'h1; rd2_d = 32'h2;
      instructionf = 32'h0; pc_plus_4f = 32'h0;
      step();
      instructionf = ins; pc_plus_4f = pc4;
      step();
      instructionf = 32'h0; pc_plus_4f = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_hazards();
      rd1_d = 32'h0; rd2_d = 32'h0;
      instructionf = 32'h1234_5678; pc_plus_4f = 32'h40;
      repeat (3) step();
      total_cnt++; if (instr_d !== 32'h0) $display("FAIL reset_instr_d got=%h exp=%h", instr_d, 32'h0); else pass_cnt++;
      total_cnt++; if (pc_plus_4d !== 32'h0) $display("FAIL reset_pc4d got=%h exp=%h", pc_plus_4d, 32'h0); else pass_cnt++;
      total_cnt++; if (pcsrc_d !== 1'b0) $display("FAIL reset_pcsrc got=%b exp=0", pcsrc_d); else pass_cnt++;
      total_cnt++; if (stallf !== 1'b0) $display("FAIL reset_stallf got=%b exp=0", stallf); else pass_cnt++;
      total_cnt++; if (flush_e !== 1'b0) $display("FAIL reset_flush_e got=%b exp=0", flush_e); else pass_cnt++;
      total_cnt++; if (pc_branch_d !== 32'h0) $display("FAIL reset_pc_branch got=%h exp=%h", pc_branch_d, 32'h0); else pass_cnt++;
      reset = 1'b0;
      step();
      total_cnt++; if (instr_d !== 32'h1234_5678) $display("FAIL first_load got=%h exp=%h", instr_d, 32'h1234_5678); else pass_cnt++;
      total_cnt++; if (pc_plus_4d !== 32'h40) $display("FAIL first_load_pc4 got=%h exp=%h", pc_plus_4d, 32'h40); else pass_cnt++;
   endtask

   task automatic test_beq_taken();
      load(32'h1022_0003, 32'h104);  // beq $1,$2,+3
      rd1_d = 32'd7; rd2_d = 32'd7;
      #1;
      total_cnt++; if (pcsrc_d !== 1'b1) $display("FAIL beq_pcsrc got=%b exp=1", pcsrc_d); else pass_cnt++;
      total_cnt++; if (pc_branch_d !== 32'h110) $display("FAIL beq_target got=%h exp=%h", pc_branch_d, 32'h110); else pass_cnt++;
      total_cnt++; if (signimm_d !== 32'h3) $display("FAIL beq_signimm got=%h exp=%h", signimm_d, 32'h3); else pass_cnt++;
      instructionf = 32'hDEAD_BEEF; pc_plus_4f = 32'h108;
      step();
      total_cnt++; if (instr_d !== 32'h0) $display("FAIL beq_squash got=%h exp=%h", instr_d, 32'h0); else pass_cnt++;
      total_cnt++; if (pc_plus_4d !== 32'h0) $display("FAIL beq_squash_pc4 got=%h exp=%h", pc_plus_4d, 32'h0); else pass_cnt++;
   endtask

   task automatic test_bne_wrap();
      load(32'h1422_FFFF, 32'h0);  // bne $1,$2,-1
      rd1_d = 32'd5; rd2_d = 32'd5;
      #1;
      total_cnt++; if (pcsrc_d !== 1'b0) $display("FAIL bne_equal_pcsrc got=%b exp=0", pcsrc_d); else pass_cnt++;
      rd1_d = 32'd6;
      #1;
      total_cnt++; if (pcsrc_d !== 1'b1) $display("FAIL bne_ne_pcsrc got=%b exp=1", pcsrc_d); else pass_cnt++;
      total_cnt++; if (pc_branch_d !== 32'hFFFF_FFFC) $display("FAIL bne_wrap_target got=%h exp=%h", pc_branch_d, 32'hFFFF_FFFC); else pass_cnt++;
      total_cnt++; if (signimm_d !== 32'hFFFF_FFFF) $display("FAIL bne_signimm got=%h exp=%h", signimm_d, 32'hFFFF_FFFF); else pass_cnt++;
   endtask

   task automatic test_load_use();
      load(32'h0065_2020, 32'h200);  // add $4,$3,$5
      total_cnt++; if (rs_d !== 5'd3 || rt_d !== 5'd5 || rd_d !== 5'd4)
         $display("FAIL add_fields got=%0d/%0d/%0d exp=3/5/4", rs_d, rt_d, rd_d); else pass_cnt++;
      memtoreg_e = 1'b1; regwrite_e = 1'b1; writereg_e = 5'd3;
      #1;
      total_cnt++; if (stallf !== 1'b1) $display("FAIL lw_stallf got=%b exp=1", stallf); else pass_cnt++;
      total_cnt++; if (flush_e !== 1'b1) $display("FAIL lw_flush_e got=%b exp=1", flush_e); else pass_cnt++;
      instructionf = 32'h1111_1111; pc_plus_4f = 32'h204;
      step();
      total_cnt++; if (instr_d !== 32'h0065_2020) $display("FAIL lw_hold got=%h exp=%h", instr_d, 32'h0065_2020); else pass_cnt++;
      total_cnt++; if (pc_plus_4d !== 32'h200) $display("FAIL lw_hold_pc4 got=%h exp=%h", pc_plus_4d, 32'h200); else pass_cnt++;
      clear_hazards();
      #1;
      total_cnt++; if (stallf !== 1'b0) $display("FAIL lw_release got=%b exp=0", stallf); else pass_cnt++;
      // a load targeting $0 never stalls a NOP reading $0
      load(32'h0, 32'h300);
      memtoreg_e = 1'b1; regwrite_e = 1'b1; writereg_e = 5'd0;
      #1;
      total_cnt++; if (stallf !== 1'b0) $display("FAIL zero_reg_stall got=%b exp=0", stallf); else pass_cnt++;
      clear_hazards();
   endtask

   task automatic test_branch_stall();
      load(32'h1060_0001, 32'h300);  // beq $3,$0,+1
      regwrite_e = 1'b1; writereg_e = 5'd3;
      rd1_d = 32'd5; rd2_d = 32'd0;
      #1;
      total_cnt++; if (stallf !== 1'b1) $display("FAIL br_stallf got=%b exp=1", stallf); else pass_cnt++;
      total_cnt++; if (pcsrc_d !== 1'b0) $display("FAIL br_stall_pcsrc got=%b exp=0", pcsrc_d); else pass_cnt++;
      step();
      regwrite_e = 1'b0; writereg_e = 5'd0;
      regwrite_m = 1'b1; writereg_m = 5'd3; aluout_m = 32'd0;
      #1;
      total_cnt++; if (instr_d !== 32'h1060_0001) $display("FAIL br_hold got=%h exp=%h", instr_d, 32'h1060_0001); else pass_cnt++;
      total_cnt++; if (stallf !== 1'b0) $display("FAIL br_release got=%b exp=0", stallf); else pass_cnt++;
      total_cnt++; if (pcsrc_d !== 1'b1) $display("FAIL br_fwd_pcsrc got=%b exp=1", pcsrc_d); else pass_cnt++;
      total_cnt++; if (pc_branch_d !== 32'h304) $display("FAIL br_fwd_target got=%h exp=%h", pc_branch_d, 32'h304); else pass_cnt++;
      clear_hazards();
   endtask

   task automatic test_jump_reset();
      load(32'h0800_0040, 32'hA000_0008);  // j 0x40
      rd1_d = 32'h1; rd2_d = 32'h2;
      #1;
      total_cnt++; if (pcsrc_d !== 1'b1) $display("FAIL j_pcsrc got=%b exp=1", pcsrc_d); else pass_cnt++;
      total_cnt++; if (pc_branch_d !== 32'hA000_0100) $display("FAIL j_target got=%h exp=%h", pc_branch_d, 32'hA000_0100); else pass_cnt++;
      reset = 1'b1;
      instructionf = 32'h5555_5555; pc_plus_4f = 32'h44;
      step();
      reset = 1'b0;
      #1;
      total_cnt++; if (pcsrc_d !== 1'b0) $display("FAIL j_reset_pcsrc got=%b exp=0", pcsrc_d); else pass_cnt++;
      total_cnt++; if (instr_d !== 32'h0) $display("FAIL j_reset_instr got=%h exp=%h", instr_d, 32'h0); else pass_cnt++;
      total_cnt++; if (pc_plus_4d !== 32'h0) $display("FAIL j_reset_pc4 got=%h exp=%h", pc_plus_4d, 32'h0); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_beq_taken();
      test_bne_wrap();
      test_load_use();
      test_branch_stall();
      test_jump_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
